// File: rtl/tsens_pkg.sv
// tsens_pkg: shared types, default sizes and helpers for the temperature-sensor readout.
package tsens_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        ACCUM,
        PRESENT
    } state_t;

    localparam int CNT_W_DEF   = 12;
    localparam int TIMEOUT_DEF = 4000;

    // Averaging accumulator must hold 2**avg_log2 full-scale samples without overflow.
    function automatic int acc_width(input int cnt_w, input int avg_log2);
        return cnt_w + avg_log2;
    endfunction

endpackage

// File: rtl/tsens_sync.sv
// tsens_sync: STAGES-flop synchronizer for an asynchronous level, reset to 0.
//   clk   in  system clock
//   reset in  asynchronous active-high reset
//   d     in  asynchronous input
//   q     out synchronized output
module tsens_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] s;

    always_ff @(posedge clk or posedge reset)
        if (reset) s <= '0;
        else       s <= {s[STAGES-2:0], d};

    assign q = s[STAGES-1];

endmodule

// File: rtl/tsens_readout.sv
// tsens_readout: times the sensor charge window (meas_en rise to comparator trip) and presents the count over valid/ready.
//   clk, reset        clock, asynchronous active-high reset
//   meas_en           measurement window from the controller (clk-synchronous)
//   cmp               raw asynchronous comparator output
//   clr_flags         pulse clearing the sticky flags
//   out_ready         host accepts out_data
//   out_valid/out_data result handshake (CNT_W-bit temperature code)
//   out_ovf, err_abort, err_overrun  sticky error flags
//   busy              high while measuring or accumulating
// Optional averaging over 2**AVG_LOG2 samples is enabled by defining TSENS_AVG_EN.
module tsens_readout
    import tsens_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int AVG_LOG2    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             meas_en,
    input  logic             cmp,
    input  logic             clr_flags,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             err_abort,
    output logic             err_overrun,
    output logic             busy
);

    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    state_t           state;
    logic             cmp_s;
    logic             meas_q;
    logic             meas_rise;
    logic             timeout;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] sample;
    logic             ovf_set;
    logic             abort_set;
    logic             overrun_set;

    tsens_sync #(.STAGES(SYNC_STAGES)) u_cmp_sync (
        .clk  (clk),
        .reset(reset),
        .d    (cmp),
        .q    (cmp_s)
    );

    assign meas_rise   = meas_en & ~meas_q;
    assign timeout     = cnt == TO;
    assign ovf_set     = state == MEASURE && !cmp_s && timeout;
    assign abort_set   = state == MEASURE && !cmp_s && !timeout && !meas_en;
    assign overrun_set = state == PRESENT && meas_rise;

`ifdef TSENS_AVG_EN
    localparam int AW = acc_width(CNT_W, AVG_LOG2);
    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_next;
    logic [AVG_LOG2-1:0] idx;
    assign acc_next = acc + {{AVG_LOG2{1'b0}}, sample};
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= IDLE;
            meas_q      <= 1'b1; // a meas_en already high at reset release is not an edge
            cnt         <= '0;
            sample      <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_ovf     <= 1'b0;
            err_abort   <= 1'b0;
            err_overrun <= 1'b0;
            busy        <= 1'b0;
`ifdef TSENS_AVG_EN
            acc         <= '0;
            idx         <= '0;
`endif
        end else begin
            meas_q      <= meas_en;
            out_ovf     <= ovf_set     | (out_ovf     & ~clr_flags);
            err_abort   <= abort_set   | (err_abort   & ~clr_flags);
            err_overrun <= overrun_set | (err_overrun & ~clr_flags);
            case (state)
                IDLE:
                    if (meas_rise) begin
                        cnt   <= '0;
                        state <= MEASURE;
                        busy  <= 1'b1;
                    end
                MEASURE: begin
                    cnt <= cnt + 1'b1;
                    // On timeout cnt equals TIMEOUT, so cnt is the sample in both cases.
                    if (cmp_s || timeout) begin
                        sample <= cnt;
                        state  <= ACCUM;
                    end else if (!meas_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ACCUM: begin
                    busy <= 1'b0;
`ifdef TSENS_AVG_EN
                    idx <= idx + 1'b1;
                    if (&idx) begin
                        acc       <= '0;
                        out_data  <= acc_next[AW-1:AVG_LOG2];
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end else begin
                        acc   <= acc_next;
                        state <= IDLE;
                    end
`else
                    out_data  <= sample;
                    out_valid <= 1'b1;
                    state     <= PRESENT;
`endif
                end
                PRESENT:
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
            endcase
        end

endmodule

// File: tb/tb_tsens_readout.sv
// tb_tsens_readout: directed self-checking bench for tsens_readout.
module tb_tsens_readout;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        meas_en = 1'b0;
    logic        cmp = 1'b0;
    logic        clr_flags = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [11:0] out_data;
    logic        out_ovf;
    logic        err_abort;
    logic        err_overrun;
    logic        busy;
    int          tests = 0;
    int          fails = 0;

    tsens_readout #(
        .CNT_W      (12),
        .TIMEOUT    (4000),
        .AVG_LOG2   (2),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .meas_en    (meas_en),
        .cmp        (cmp),
        .clr_flags  (clr_flags),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .err_abort  (err_abort),
        .err_overrun(err_overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Window with meas_en rising now and cmp arriving n cycles later; sample becomes n+1.
    task automatic measure(input int n);
        meas_en = 1'b1;
        repeat (n) tick();
        cmp = 1'b1;
        repeat (5) tick();
        meas_en = 1'b0;
        cmp = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {out_ovf, err_abort, err_overrun}, 0);
        reset = 1'b0;
        tick();
`ifdef TSENS_AVG_EN
        measure(99);
        check("avg_s1_valid", out_valid, 0);
        measure(100);
        check("avg_s2_valid", out_valid, 0);
        meas_en = 1'b1;
        repeat (30) tick();
        meas_en = 1'b0;
        tick();
        check("avg_abort", err_abort, 1);
        check("avg_abort_valid", out_valid, 0);
        repeat (2) tick();
        measure(102);
        check("avg_s3_valid", out_valid, 0);
        measure(103);
        check("avg_valid", out_valid, 1);
        check("avg_data", out_data, 102);
        check("avg_ovf", out_ovf, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("avg_drop", out_valid, 0);
`else
        meas_en = 1'b1;
        repeat (100) tick();
        check("busy_measure", busy, 1);
        cmp = 1'b1;
        repeat (3) tick();
        check("lat_early", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("data_101", out_data, 101);
        check("busy_present", busy, 0);
        repeat (10) tick();
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, 101);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drop_valid", out_valid, 0);
        meas_en = 1'b0;
        cmp = 1'b0;
        repeat (4) tick();

        meas_en = 1'b1;
        for (int i = 0; i < 5000 && !out_valid; i++) tick();
        check("to_valid", out_valid, 1);
        check("to_data", out_data, 4000);
        check("to_ovf", out_ovf, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        meas_en = 1'b0;
        check("ovf_sticky", out_ovf, 1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("ovf_clr", out_ovf, 0);
        repeat (3) tick();

        meas_en = 1'b1;
        repeat (50) tick();
        meas_en = 1'b0;
        tick();
        check("abort_flag", err_abort, 1);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        repeat (2) tick();
        measure(20);
        check("post_abort_valid", out_valid, 1);
        check("post_abort_data", out_data, 21);

        meas_en = 1'b1;
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("overrun_set_wins", err_overrun, 1);
        check("abort_cleared", err_abort, 0);
        check("overrun_valid", out_valid, 1);
        cmp = 1'b1;
        repeat (5) tick();
        check("overrun_data", out_data, 21);
        check("overrun_busy", busy, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("overrun_drop", out_valid, 0);
        repeat (3) tick();
        check("overrun_ignored", busy, 0);
        check("overrun_sticky", err_overrun, 1);
        meas_en = 1'b0;
        cmp = 1'b0;
        repeat (4) tick();

        meas_en = 1'b1;
        repeat (61) tick();
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_overrun", err_overrun, 0);
        #3 reset = 1'b0;
        repeat (3) tick();
        check("no_rise_at_release", busy, 0);
        meas_en = 1'b0;
        tick();
        measure(40);
        check("fresh_valid", out_valid, 1);
        check("fresh_data", out_data, 41);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
